// File: rtl/pre_proc_pkg.sv
// Shared types for the pixel-to-feature pre-processing block.
// PRE_PROC_ZERO_CENTER_EN selects pixel-128 conversion instead of a raw signed reinterpretation.
package pre_proc_pkg;

  localparam int unsigned NumLanesDefault = 6;

  typedef logic signed [7:0] feature_t;
  typedef logic [NumLanesDefault-1:0] lane_mask_t;

  typedef enum logic [1:0] {StIdle, StCollect, StStall} state_e;

  function automatic feature_t pixel_to_feature(input logic [7:0] pix);
`ifdef PRE_PROC_ZERO_CENTER_EN
    // Inverting the MSB is pixel-128 in two's complement.
    return feature_t'({~pix[7], pix[6:0]});
`else
    return feature_t'(pix);
`endif
  endfunction

endpackage

// File: rtl/pre_proc_out_slot.sv
// Single-entry valid/ready holding register for one feature vector plus its mask and frame flags.
module pre_proc_out_slot
  import pre_proc_pkg::*;
#(
  parameter int unsigned NumLanes = NumLanesDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  feature_t            in_data_i [NumLanes],
  input  logic [NumLanes-1:0] in_mask_i,
  input  logic                in_first_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output feature_t            out_data_o [NumLanes],
  output logic [NumLanes-1:0] out_mask_o,
  output logic                out_first_o,
  output logic                out_last_o
);

  logic                valid_q;
  feature_t            data_q [NumLanes];
  logic [NumLanes-1:0] mask_q;
  logic                first_q;
  logic                last_q;

  // Accept a new entry when empty or when the current one leaves this cycle.
  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '{default: '0};
      mask_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (in_ready_o) begin
        valid_q <= in_valid_i;
      end
      if (in_valid_i && in_ready_o) begin
        data_q  <= in_data_i;
        mask_q  <= in_mask_i;
        first_q <= in_first_i;
        last_q  <= in_last_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_mask_o  = mask_q;
  assign out_first_o = first_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/pre_processing.sv
// Widens an 8-bit pixel stream into NUM_LANES-wide feature vectors, zero-padding each frame's tail.
// Build with PRE_PROC_ZERO_CENTER_EN defined to store pixels as pixel-128.
module pre_processing
  import pre_proc_pkg::*;
#(
  parameter int unsigned NUM_LANES    = NumLanesDefault,
  parameter int unsigned FRAME_PIXELS = 784
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pixel_valid,
  output logic                 o_pixel_ready,
  input  logic [7:0]           i_pixel_in,
  input  logic                 i_frame_start,
  output logic                 o_features_valid,
  input  logic                 i_features_ready,
  output feature_t             o_features_out [0:NUM_LANES-1],
  output logic [NUM_LANES-1:0] o_lane_mask,
  output logic                 o_features_first,
  output logic                 o_features_last,
  output logic                 o_sync_error
);

  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned PixW  = $clog2(FRAME_PIXELS + 1);
  localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_LANES - 1);
  localparam logic [PixW-1:0]  LastPix  = PixW'(FRAME_PIXELS - 1);

  state_e           state_q, state_d;
  feature_t         lanes_q [NUM_LANES];
  feature_t         lanes_d [NUM_LANES];
  feature_t         asm_vec [NUM_LANES];
  logic [LaneW-1:0] lane_cnt_q, lane_cnt_d;
  logic [PixW-1:0]  pix_cnt_q, pix_cnt_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             sync_err_q, sync_err_d;
  logic             ready_q;

  logic                 accept, restart, take, complete;
  logic [LaneW-1:0]     lane_idx;
  logic [PixW-1:0]      pix_idx;
  logic                 asm_first, asm_last;
  logic                 push_valid, slot_ready;
  feature_t             push_data [NUM_LANES];
  logic [NUM_LANES-1:0] push_mask;
  logic                 push_first, push_last;

  function automatic logic [NUM_LANES-1:0] mask_upto(input logic [LaneW-1:0] idx);
    logic [NUM_LANES-1:0] m;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      m[i] = (i <= 32'(idx));
    end
    return m;
  endfunction

  assign o_pixel_ready = ready_q && (state_q != StStall);
  assign accept        = i_pixel_valid && o_pixel_ready;
  // A frame-start pixel always begins a fresh vector, dropping any partial assembly.
  assign restart       = accept && i_frame_start;
  assign lane_idx      = restart ? '0 : lane_cnt_q;
  assign pix_idx       = restart ? '0 : pix_cnt_q;
  assign asm_first     = restart || first_q;
  assign asm_last      = (pix_idx == LastPix);
  assign complete      = (lane_idx == LastLane) || asm_last;

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    lane_cnt_d = lane_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    first_d    = first_q;
    last_d     = last_q;
    sync_err_d = sync_err_q;
    take       = 1'b0;

    asm_vec = lanes_q;
    if (restart) begin
      asm_vec = '{default: '0};
    end
    asm_vec[lane_idx] = pixel_to_feature(i_pixel_in);

    push_valid = 1'b0;
    push_data  = asm_vec;
    push_mask  = mask_upto(lane_idx);
    push_first = asm_first;
    push_last  = asm_last;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (i_frame_start) take = 1'b1;
          else               sync_err_d = 1'b1;
        end
      end
      StCollect: begin
        if (accept) begin
          take = 1'b1;
          if (i_frame_start) sync_err_d = 1'b1;
        end
      end
      StStall: begin
        // lane_cnt_q holds the last filled lane of the parked vector.
        push_data  = lanes_q;
        push_mask  = mask_upto(lane_cnt_q);
        push_first = first_q;
        push_last  = last_q;
        if (slot_ready) begin
          push_valid = 1'b1;
          lanes_d    = '{default: '0};
          lane_cnt_d = '0;
          first_d    = 1'b0;
          state_d    = last_q ? StIdle : StCollect;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      if (complete) begin
        pix_cnt_d = asm_last ? '0 : pix_idx + PixW'(1);
        if (slot_ready) begin
          push_valid = 1'b1;
          lanes_d    = '{default: '0};
          lane_cnt_d = '0;
          first_d    = 1'b0;
          state_d    = asm_last ? StIdle : StCollect;
        end else begin
          lanes_d    = asm_vec;
          lane_cnt_d = lane_idx;
          first_d    = asm_first;
          last_d     = asm_last;
          state_d    = StStall;
        end
      end else begin
        lanes_d    = asm_vec;
        lane_cnt_d = lane_idx + LaneW'(1);
        pix_cnt_d  = pix_idx + PixW'(1);
        first_d    = asm_first;
        state_d    = StCollect;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      lanes_q    <= '{default: '0};
      lane_cnt_q <= '0;
      pix_cnt_q  <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      sync_err_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      lane_cnt_q <= lane_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      first_q    <= first_d;
      last_q     <= last_d;
      sync_err_q <= sync_err_d;
      ready_q    <= 1'b1;
    end
  end

  assign o_sync_error = sync_err_q;

  pre_proc_out_slot #(
    .NumLanes(NUM_LANES)
  ) u_out_slot (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .in_valid_i (push_valid),
    .in_ready_o (slot_ready),
    .in_data_i  (push_data),
    .in_mask_i  (push_mask),
    .in_first_i (push_first),
    .in_last_i  (push_last),
    .out_valid_o(o_features_valid),
    .out_ready_i(i_features_ready),
    .out_data_o (o_features_out),
    .out_mask_o (o_lane_mask),
    .out_first_o(o_features_first),
    .out_last_o (o_features_last)
  );

endmodule

// File: tb/tb_pre_processing.sv
// Directed bench: a 12-pixel-frame instance for protocol cases and a default 784-pixel instance.
module tb_pre_processing;
  import pre_proc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       s_valid, s_start, s_fready, s_ready, s_fvalid, s_first, s_last, s_err;
  logic [7:0] s_pix;
  logic [5:0] s_mask;
  feature_t   s_out [0:5];

  logic       l_valid, l_start, l_fready, l_ready, l_fvalid, l_first, l_last, l_err;
  logic [7:0] l_pix;
  logic [5:0] l_mask;
  feature_t   l_out [0:5];

  int checks = 0;
  int errors = 0;

  logic [47:0] s_qd[$];
  logic [5:0]  s_qm[$];
  logic        s_qf[$];
  logic        s_ql[$];
  logic [47:0] l_qd[$];
  logic [5:0]  l_qm[$];
  logic        l_qf[$];
  logic        l_ql[$];

  pre_processing #(.NUM_LANES(6), .FRAME_PIXELS(12)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_valid(s_valid), .o_pixel_ready(s_ready),
    .i_pixel_in(s_pix), .i_frame_start(s_start), .o_features_valid(s_fvalid),
    .i_features_ready(s_fready), .o_features_out(s_out), .o_lane_mask(s_mask),
    .o_features_first(s_first), .o_features_last(s_last), .o_sync_error(s_err)
  );

  pre_processing #(.NUM_LANES(6), .FRAME_PIXELS(784)) dut_l (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_valid(l_valid), .o_pixel_ready(l_ready),
    .i_pixel_in(l_pix), .i_frame_start(l_start), .o_features_valid(l_fvalid),
    .i_features_ready(l_fready), .o_features_out(l_out), .o_lane_mask(l_mask),
    .o_features_first(l_first), .o_features_last(l_last), .o_sync_error(l_err)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] flat6(input feature_t v [0:5]);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[47-8*i -: 8] = v[i];
    return r;
  endfunction

  function automatic logic [47:0] seqv(input int base, input int n);
    logic [47:0] r;
    for (int k = 0; k < 6; k++) r[47-8*k -: 8] = (k < n) ? 8'(base + k) : 8'h00;
    return r;
  endfunction

  // Record every vector transfer; sampled mid-cycle so the values are settled.
  always @(negedge clk) begin
    if (s_fvalid && s_fready) begin
      s_qd.push_back(flat6(s_out)); s_qm.push_back(s_mask);
      s_qf.push_back(s_first);      s_ql.push_back(s_last);
    end
    if (l_fvalid && l_fready) begin
      l_qd.push_back(flat6(l_out)); l_qm.push_back(l_mask);
      l_qf.push_back(l_first);      l_ql.push_back(l_last);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    s_qd.delete(); s_qm.delete(); s_qf.delete(); s_ql.delete();
  endtask

  task automatic send(input bit big, input logic [7:0] p, input logic st);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    if (big) begin l_valid = 1'b1; l_pix = p; l_start = st; end
    else     begin s_valid = 1'b1; s_pix = p; s_start = st; end
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = big ? l_ready : s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_accepted", 64'(acc), 64'd1);
    if (big) l_valid = 1'b0;
    else     s_valid = 1'b0;
  endtask

  initial begin
    logic [47:0] held;
    int          acc_cnt, bad;
    logic [7:0]  zc_pix [0:11];

    s_valid = 0; s_start = 0; s_pix = 0; s_fready = 1;
    l_valid = 0; l_start = 0; l_pix = 0; l_fready = 1;
    rst_n = 1'b0;

    // Reset state
    tick(1);
    check("rst_ready", s_ready, 1'b0);
    check("rst_valid", s_fvalid, 1'b0);
    check("rst_mask", s_mask, 6'h00);
    check("rst_data", flat6(s_out), 48'h0);
    check("rst_first_last", {s_first, s_last}, 2'b00);
    check("rst_sync_err", s_err, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("ready_before_first_clk", s_ready, 1'b0);
    tick(1);
    check("ready_after_first_clk", s_ready, 1'b1);

    // Orphan pixel without frame start is dropped and flagged
    send(1'b0, 8'h05, 1'b0);
    tick(3);
    check("orphan_sync_err", s_err, 1'b1);
    check("orphan_no_vector", s_qd.size(), 0);
    check("orphan_valid", s_fvalid, 1'b0);
    rst_n = 1'b0; #1;
    check("rst_clears_sync_err", s_err, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);

    // Single 12-pixel frame, downstream always ready
    clear_q();
    for (int i = 1; i <= 12; i++) begin
      send(1'b0, 8'(i), i == 1);
      if (i == 5) check("t1_no_valid_before_6th", s_fvalid, 1'b0);
      if (i == 6) check("t1_valid_after_6th", s_fvalid, 1'b1);
    end
    tick(3);
    check("t1_count", s_qd.size(), 2);
    check("t1_v0_data", s_qd[0], seqv(1, 6));
    check("t1_v0_mask", s_qm[0], 6'h3F);
    check("t1_v0_first_last", {s_qf[0], s_ql[0]}, 2'b10);
    check("t1_v1_data", s_qd[1], seqv(7, 6));
    check("t1_v1_first_last", {s_qf[1], s_ql[1]}, 2'b01);

    // Downstream stall: slot holds one vector, assembly fills, then block stalls
    clear_q();
    s_fready = 1'b0;
    for (int i = 21; i <= 32; i++) send(1'b0, 8'(i), i == 21);
    check("stall_ready_low", s_ready, 1'b0);
    held = flat6(s_out);
    s_valid = 1'b1; s_pix = 8'd33; s_start = 1'b1;
    acc_cnt = 0;
    bad     = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_ready) acc_cnt++;
      if (flat6(s_out) !== held || !s_fvalid) bad++;
      @(posedge clk); #1;
    end
    check("stall_no_accept", acc_cnt, 0);
    check("stall_held_stable", bad, 0);
    check("stall_held_data", held, seqv(21, 6));
    s_fready = 1'b1;
    for (int i = 33; i <= 44; i++) send(1'b0, 8'(i), i == 33);
    tick(3);
    check("stall_count", s_qd.size(), 4);
    check("stall_v0", s_qd[0], seqv(21, 6));
    check("stall_v1", s_qd[1], seqv(27, 6));
    check("stall_v1_last", s_ql[1], 1'b1);
    check("stall_v2", s_qd[2], seqv(33, 6));
    check("stall_v2_first", s_qf[2], 1'b1);
    check("stall_v3", s_qd[3], seqv(39, 6));

    // Resync: frame start on the 10th pixel of a frame
    clear_q();
    check("pre_resync_err", s_err, 1'b0);
    for (int i = 1; i <= 9; i++) send(1'b0, 8'(i), i == 1);
    for (int i = 101; i <= 112; i++) send(1'b0, 8'(i), i == 101);
    tick(3);
    check("resync_err", s_err, 1'b1);
    check("resync_count", s_qd.size(), 3);
    check("resync_v0", s_qd[0], seqv(1, 6));
    check("resync_v1", s_qd[1], seqv(101, 6));
    check("resync_v1_first", {s_qf[1], s_ql[1]}, 2'b10);
    check("resync_v2_last", {s_qd[2], s_ql[2]}, {seqv(107, 6), 1'b1});

    // Reset mid-frame while a vector is held
    clear_q();
    s_fready = 1'b0;
    for (int i = 1; i <= 6; i++) send(1'b0, 8'(i), i == 1);
    send(1'b0, 8'd7, 1'b0);
    check("pre_reset_valid", s_fvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", s_ready, 1'b0);
    check("midrst_valid", s_fvalid, 1'b0);
    check("midrst_data", flat6(s_out), 48'h0);
    check("midrst_mask", s_mask, 6'h00);
    check("midrst_flags", {s_first, s_last, s_err}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    s_fready = 1'b1;
    tick(1);
    clear_q();
    for (int i = 1; i <= 12; i++) send(1'b0, 8'(i + 60), i == 1);
    tick(3);
    check("postrst_count", s_qd.size(), 2);
    check("postrst_v0", s_qd[0], seqv(61, 6));
    check("postrst_v1", s_qd[1], seqv(67, 6));

    // Pixel conversion
    clear_q();
    zc_pix = '{8'h00, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 12; i++) send(1'b0, zc_pix[i], i == 0);
    tick(3);
`ifdef PRE_PROC_ZERO_CENTER_EN
    check("conv_v0", s_qd[0], 48'h80_00_7F_80_80_80);
`else
    check("conv_v0", s_qd[0], 48'h00_80_FF_00_00_00);
`endif

    // Default 784-pixel frame, continuous input
    for (int i = 1; i <= 784; i++) send(1'b1, 8'(i), i == 1);
    tick(3);
    check("big_count", l_qd.size(), 131);
    check("big_v0", {l_qd[0], l_qf[0], l_ql[0]}, {seqv(1, 6), 2'b10});
    check("big_v129", {l_qd[129], l_qm[129], l_ql[129]}, {seqv(775, 6), 6'h3F, 1'b0});
    check("big_v130_data", l_qd[130], seqv(781, 4));
    check("big_v130_mask", l_qm[130], 6'h0F);
    check("big_v130_flags", {l_qf[130], l_ql[130]}, 2'b01);
    check("big_sync_err", l_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pre_processing.md
Name: pre_processing

Overview:
- Input-side counterpart of the pool-layer post-processing reducer.
- Accepts one 8-bit pixel per cycle from the narrow pin interface and widens the stream into NUM_LANES-wide feature vectors for the first conv layer.
- Tracks frame boundaries and zero-pads the final partial vector of each frame.
- Valid/ready on both sides; one assembly register plus a single-entry output slot lets input continue while the output is held.

Parameters:
- NUM_LANES, 6: features per output vector.
- FRAME_PIXELS, 784: pixels per frame (28x28). Need not be a multiple of NUM_LANES.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pixel_valid  in  1  pixel present on i_pixel_in.
- o_pixel_ready  out  1  block accepts a pixel this cycle.
- i_pixel_in  in  8  unsigned pixel.
- i_frame_start  in  1  qualifies the pixel on i_pixel_in as the first pixel of a frame.
- o_features_valid  out  1  output vector valid.
- i_features_ready  in  1  downstream accepts the vector.
- o_features_out  out  signed 8 x NUM_LANES  unpacked array [0:NUM_LANES-1]; lane 0 = earliest pixel.
- o_lane_mask  out  NUM_LANES  bit i set = lane i holds a real pixel.
- o_features_first  out  1  vector is the first of its frame.
- o_features_last  out  1  vector is the last of its frame.
- o_sync_error  out  1  sticky protocol-error flag.

Behaviour:
- A pixel is accepted when i_pixel_valid && o_pixel_ready. A vector transfers when o_features_valid && i_features_ready.
- Reset (async assert, sync deassert use):
  - Outputs: o_pixel_ready=0 in the cycle reset is asserted, 1 from the first clock after release. o_features_valid=0, o_features_out all 0, o_lane_mask=0, first/last=0, o_sync_error=0.
  - State = IDLE; lane counter and pixel counter = 0.
  - Reset mid-frame discards all partial data.
- States:
  - IDLE: ready=1.
    - Accepted pixel with i_frame_start=1 -> stored in lane 0, pixel count=1, go to COLLECT.
    - Accepted pixel with i_frame_start=0 -> discarded, o_sync_error set, stay IDLE.
  - COLLECT: ready=1. Each accepted pixel is written to lane[lane_cnt], and lane_cnt and pix_cnt increment.
    - The vector is complete when lane_cnt reaches NUM_LANES-1 or pix_cnt reaches FRAME_PIXELS-1.
    - On completion, if the output slot is empty or being consumed this cycle, the vector moves to the slot at the next edge. Otherwise go to STALL.
    - After the frame's final pixel completes its vector, go to IDLE. Otherwise stay in COLLECT with lane_cnt=0.
  - STALL: ready=0. Wait for the slot to free, then move the vector to the slot and go to COLLECT (or IDLE if this was the frame's final vector).
- Latency: the pixel completing a vector is accepted at edge N; o_features_valid is high after edge N. One-cycle pipeline, full throughput when i_features_ready=1.
- Partial final vector:
  - Unfilled lanes are 0.
  - o_lane_mask has ones only in the filled low lanes.
  - o_features_last=1.
  - Full vectors have mask = all ones.
- o_features_first=1 only on the vector containing pixel 0.
- i_frame_start=1 on an accepted pixel while in COLLECT (resync):
  - Partial assembly is discarded and never emitted.
  - o_sync_error is set.
  - The pixel becomes lane 0 of a new frame; counters restart.
  - A vector already in the slot is unaffected.
- The output slot holds data stable while valid && !ready.

Optional Feature:
- Macro PRE_PROC_ZERO_CENTER_EN.
- Defined: each pixel is converted to signed as pixel-128 (MSB inverted) before storage. Pixel 0x00 -> -128, 0xFF -> +127. Padding lanes remain 0.
- Undefined: raw bits are reinterpreted as signed, so 0xFF -> -1.

Decomposition:
- Package pre_proc_pkg holds:
  - NUM_LANES default constant.
  - feature_t (logic signed [7:0]).
  - lane_mask_t.
  - state enum {IDLE, COLLECT, STALL}.
- One natural sub-module: pre_proc_out_slot, a single-entry valid/ready register carrying vector, mask, first and last.

Test Plan:
- Single frame, FRAME_PIXELS=12, pixels 1..12, ready always 1 -> two vectors {1..6} and {7..12}, mask 0x3F, first on vector 0, last on vector 1, each valid one cycle after its 6th pixel.
- Default 784-pixel frame, continuous input -> 131 vectors. Vector 130 carries pixels 781..784, lanes 4-5 = 0, mask 0x0F, last=1.
- i_features_ready held 0 for 20 cycles mid-frame -> exactly 6 more pixels accepted, then o_pixel_ready=0 (STALL). Held vector is stable. Release -> no pixel loss or duplication.
- i_frame_start asserted on pixel 10 of a frame -> partial vector (pixels 7-9) dropped, o_sync_error=1, next vector starts at the new frame's pixel with first=1.
- Pixel without i_frame_start after reset -> dropped, o_sync_error=1, no vector output. Then assert i_rst_n=0 mid-frame -> all outputs 0 immediately.
- With PRE_PROC_ZERO_CENTER_EN, pixels 0x00, 0x80, 0xFF -> outputs -128, 0, 127. Without the macro -> 0, -128, -1.
